// File: rtl/mult_pkg.sv
// Shared types and defaults for the array-multiplier operand sequencer.
package mult_pkg;

    localparam int MULT_N_DEFAULT      = 4;
    localparam int MULT_SETTLE_DEFAULT = 2;

    typedef logic [1:0] mult_seq_state_t;

    localparam mult_seq_state_t IDLE   = 2'd0;
    localparam mult_seq_state_t SETTLE = 2'd1;
    localparam mult_seq_state_t HOLD   = 2'd2;

endpackage

// File: rtl/mult_operand_sequencer_settle_counter.sv
// Loadable down-counter; done flags the last settle cycle (count == 1).
module settle_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         done
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Saturates at zero; only a load restarts it.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done = (cnt_q == W'(1));

endmodule

// File: rtl/mult_operand_sequencer.sv
// Operand launch / product capture around a combinational array multiplier.
// Optional product self-check enabled by defining MULT_SELFCHECK_EN.
module mult_operand_sequencer
    import mult_pkg::*;
#(
    parameter int N             = MULT_N_DEFAULT,
    parameter int SETTLE_CYCLES = MULT_SETTLE_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   inputM,
    input  logic [N-1:0]   inputQ,
    output logic [N-1:0]   array_M,
    output logic [N-1:0]   array_Q,
    input  logic [2*N-1:0] array_P,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] product,
    output logic           busy,
    output logic           mismatch
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);

    mult_seq_state_t state_q, state_d;
    logic [N-1:0]    m_q, m_d;
    logic [N-1:0]    q_q, q_d;
    logic [2*N-1:0]  prod_q, prod_d;
    logic            cnt_load;
    logic            cnt_en;
    logic            cnt_done;
    logic            capture;

    assign cnt_load = (state_q == IDLE) && in_valid;
    assign cnt_en   = (state_q == SETTLE);
    assign capture  = (state_q == SETTLE) && cnt_done;

    settle_counter #(
        .W (CW)
    ) u_settle (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .load_val (CW'(SETTLE_CYCLES)),
        .en       (cnt_en),
        .done     (cnt_done)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        prod_d  = prod_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    m_d     = inputM;
                    q_d     = inputQ;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_done) begin
                    prod_d  = array_P;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            m_q     <= '0;
            q_q     <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            prod_q  <= prod_d;
        end
    end

`ifdef MULT_SELFCHECK_EN
    logic [2*N-1:0] ref_p;
    logic           mis_q;

    assign ref_p = (2*N)'(m_q) * (2*N)'(q_q);

    // Sticky: once the array disagrees, keep flagging until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            mis_q <= 1'b0;
        end else if (capture && (array_P != ref_p)) begin
            mis_q <= 1'b1;
        end
    end

    assign mismatch = mis_q;
`else
    logic unused_capture;
    assign unused_capture = capture;
    assign mismatch       = 1'b0;
`endif

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign busy      = (state_q != IDLE);
    assign array_M   = m_q;
    assign array_Q   = q_q;
    assign product   = prod_q;

endmodule

// File: tb/tb_mult_operand_sequencer.sv
// Randomised scoreboard bench for mult_operand_sequencer with a behavioural array.
module tb_mult_operand_sequencer;

    localparam int N = 4;
    localparam int S = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   inputM;
    logic [N-1:0]   inputQ;
    logic [N-1:0]   array_M;
    logic [N-1:0]   array_Q;
    logic [2*N-1:0] array_P;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] product;
    logic           busy;
    logic           mismatch;

    logic fault = 1'b0;
    bit   or_rand = 1'b0;

    typedef struct {
        int m;
        int q;
        int p;
        int acc;
        bit mis;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   sticky = 1'b0;

    always #5 clk = ~clk;

    // Behavioural array, with an optional stuck-at-1 on product bit 0.
    assign array_P = ((2*N)'(array_M) * (2*N)'(array_Q)) | (2*N)'(fault);

    mult_operand_sequencer #(
        .N             (N),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inputM    (inputM),
        .inputQ    (inputQ),
        .array_M   (array_M),
        .array_Q   (array_Q),
        .array_P   (array_P),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .mismatch  (mismatch)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (or_rand) out_ready = 1'($urandom_range(0, 1));
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Monitor: pops the scoreboard on each output handshake.
    bit prev_ov = 1'b0;
    bit prev_hs = 1'b0;
    bit busy_next = 1'b0;

    always @(negedge clk) begin
        if (reset) begin
            prev_ov   = 1'b0;
            prev_hs   = 1'b0;
            busy_next = 1'b0;
        end else begin
            if (busy_next) begin
                chk("busy_after_ack", 64'(busy), 64'd0);
                busy_next = 1'b0;
            end
            if (prev_ov && !out_valid && !prev_hs)
                fail_now("valid_dropped_without_ack");
            if (out_valid && !prev_ov) begin
                if (sb.size() == 0) fail_now("spurious_out_valid");
                else chk("latency", 64'(cyc), 64'(sb[0].acc + S));
            end
            prev_hs = 1'b0;
            if (out_valid && sb.size() > 0) begin
                chk("product", 64'(product), 64'(sb[0].p));
                chk("hold_M", 64'(array_M), 64'(sb[0].m));
                chk("hold_Q", 64'(array_Q), 64'(sb[0].q));
                chk("in_ready_in_hold", 64'(in_ready), 64'd0);
                if (out_ready) begin
                    chk("mismatch", 64'(mismatch), 64'(sb[0].mis));
                    void'(sb.pop_front());
                    busy_next = 1'b1;
                    prev_hs   = 1'b1;
                end
            end
            prev_ov = out_valid;
        end
    end

    task automatic send(input int m, input int q, output int acc);
        exp_t e;
        bit   ok;
        ok       = 1'b0;
        acc      = -1;
        inputM   = N'(m);
        inputQ   = N'(q);
        in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                chk("single_in_flight", 64'(sb.size()), 64'd0);
                e.m   = m;
                e.q   = q;
                e.p   = (m * q) | int'(fault);
                e.mis = sticky || (fault && ((m * q) % 2 == 0));
                e.acc = cyc + 1;
                sticky = e.mis;
                sb.push_back(e);
                acc = e.acc;
                ok  = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        sb.delete();
        sticky = 1'b0;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_array_M", 64'(array_M), 64'd0);
        chk("rst_array_Q", 64'(array_Q), 64'd0);
        chk("rst_product", 64'(product), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_mismatch", 64'(mismatch), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int a0, a1, a2, tmp;
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inputM    = '0;
        inputQ    = '0;
        @(posedge clk);
        #1;
        do_reset();

        out_ready = 1'b1;
        send(13, 11, tmp);
        in_valid = 1'b0;
        drain();
        send(15, 15, tmp);
        in_valid = 1'b0;
        drain();
        send(0, 9, tmp);
        in_valid = 1'b0;
        drain();

        // Backpressure with a second pair waiting on in_valid.
        out_ready = 1'b0;
        send(10, 12, tmp);
        fork
            send(6, 7, a0);
            begin
                for (int i = 0; i < 50; i++) begin
                    @(negedge clk);
                    if (out_valid) break;
                end
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        in_valid = 1'b0;
        drain();

        // Reset while the result is still settling.
        send(7, 6, tmp);
        do_reset();
        send(3, 5, tmp);
        in_valid = 1'b0;
        drain();

        // Back-to-back with in_valid and out_ready held high.
        out_ready = 1'b1;
        send(2, 3, a0);
        send(5, 5, a1);
        send(9, 14, a2);
        in_valid = 1'b0;
        drain();
        chk("b2b_spacing_1", 64'(a1 - a0), 64'(S + 2));
        chk("b2b_spacing_2", 64'(a2 - a1), 64'(S + 2));

        or_rand = 1'b1;
        for (int i = 0; i < 25; i++) begin
            send(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), tmp);
            in_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        drain();
        or_rand   = 1'b0;
        out_ready = 1'b1;

`ifdef MULT_SELFCHECK_EN
        fault = 1'b1;
        send(2, 2, tmp);
        in_valid = 1'b0;
        drain();
        fault = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("mismatch_sticky", 64'(mismatch), 64'd1);
        @(posedge clk);
        #1;
        send(4, 3, tmp);
        in_valid = 1'b0;
        drain();
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

endmodule
